reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 32, register width in bits
- NREGS, 16, register count (power of two, 2..64)
- ZERO_R0, 0, 1 = register 0 reads 0 and ignores writes and issues
- BYPASS, 1, 1 = same-cycle write-to-read forwarding
REQ-002 Derived constant AW = log2(NREGS).
REQ-003 Ports SHALL be, one per line:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write/writeback strobe
- wr_ad  in  AW  write address
- wr_data  in  DATA_W  write data
- iss_en  in  1  issue strobe: destination becomes pending
- iss_ad  in  AW  issue destination address
- addr_a  in  AW  read port A address
- addr_b  in  AW  read port B address
- o_a  out  DATA_W  port A data
- o_b  out  DATA_W  port B data
- busy_a  out  1  addr_a register pending
- busy_b  out  1  addr_b register pending
- pend_cnt  out  AW+1  number of pending registers
REQ-004 The block SHALL have one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-005 A write SHALL update mem[wr_ad] at the clk edge where wr_en=1 and rst=0.
REQ-006 Reads SHALL be combinational; o_x = mem[addr_x].
REQ-007 With BYPASS=1, if wr_en=1 and wr_ad=addr_x, o_x SHALL equal wr_data in that same cycle.
REQ-008 With ZERO_R0=1, addr_x=0 SHALL give o_x=0 and busy_x=0. Writes and issues to address 0 SHALL be ignored, including for bypass.
REQ-009 Each register SHALL have a pending bit:
- iss_en sets pend[iss_ad] at the edge
- wr_en clears pend[wr_ad] at the edge
REQ-010 If wr_en and iss_en target the same address in the same cycle, set SHALL win, so the bit is 1 after the edge.
REQ-011 If they target different addresses in the same cycle, both updates SHALL apply.
REQ-012 busy_x SHALL equal pend[addr_x] for the current cycle.
REQ-013 With BYPASS=1, busy_x SHALL be 0 when wr_en=1 and wr_ad=addr_x in that cycle.
REQ-014 Issue to an already-pending register SHALL leave it pending.
REQ-015 Writeback to a non-pending register SHALL write data and leave pend unchanged.
REQ-016 pend_cnt SHALL be a registered population count of pend.
- update at each edge by +1, -1 or 0
- range 0..NREGS, never wraps
- latency 1 cycle after the causing edge

Reset
REQ-017 While rst=1 at an edge, all mem entries, all pend bits and pend_cnt SHALL become 0. wr_en and iss_en SHALL be ignored.
REQ-018 While rst=1, o_a, o_b, busy_a and busy_b SHALL be driven 0 and bypass SHALL be suppressed.
REQ-019 Reset asserted mid-operation with pending registers SHALL discard all pending state. No writeback is required afterwards.
REQ-020 Without reset, mem contents SHALL be X in simulation. The bench SHALL reset before first use.

Structure
REQ-021 Package reg_file_pkg SHALL hold:
- default constants for DATA_W and NREGS
- the AW derivation function
REQ-022 Sub-module reg_scoreboard SHALL own pend and pend_cnt. Inputs: clk, rst, set/clear strobes and addresses. Outputs: pend vector and count.
REQ-023 The storage array and the read/bypass muxes SHALL stay in reg_file_sb.

Verification
REQ-024 Reset: write all 16 regs with 0xA5A5_0000+i, pulse rst -> all reads 0, pend_cnt=0, busy=0.
REQ-025 Bypass: write r3=0x1234_5678 with addr_a=3 in the same cycle -> o_a=0x1234_5678 that cycle. Repeat with BYPASS=0 -> old value that cycle, new value next cycle.
REQ-026 Scoreboard: issue r5 -> busy_a=1 for addr_a=5 and pend_cnt=1 next cycle. Writeback r5 -> busy cleared, pend_cnt=0.
REQ-027 Collision: wr_en and iss_en both to r7 on one edge -> pend[7]=1 and r7 holds wr_data. Issue r2 while writing back r9 -> count unchanged.
REQ-028 ZERO_R0=1: write r0=0xFFFF_FFFF and issue r0 -> o_a=0, busy_a=0, pend_cnt unchanged.
REQ-029 Saturation: issue all 16 registers -> pend_cnt=16. Re-issue r1 -> stays 16. Mid-sequence rst -> 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the register file with scoreboard.
//   DATA_W_DEF  : default register width in bits
//   NREGS_DEF   : default register count
//   addr_width(): number of address bits needed for n registers
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 16;

  // ceil(log2(n)); n is a power of two, so this is exact.
  function automatic int addr_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-bit scoreboard for the register file.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   set_en, set_ad    : mark register set_ad pending (issue)
//   clr_en, clr_ad    : clear pending bit of clr_ad (writeback)
//   pend              : pending bit per register
//   cnt               : registered count of pending registers
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_ad,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_ad,
  output logic [NREGS-1:0] pend,
  output logic [AW:0]      cnt
);

  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

  logic [NREGS-1:0] pend_reg, pend_next;
  logic [AW:0]      cnt_reg, cnt_next;
  logic             inc, dec;

  always_comb begin
    pend_next = pend_reg;
    // Clear first, then set: a set to the same address wins.
    if (clr_en) pend_next[clr_ad] = 1'b0;
    if (set_en) pend_next[set_ad] = 1'b1;

    // The count tracks the population of pend incrementally: only a
    // 0->1 transition adds and only a 1->0 transition subtracts.
    inc = set_en && !pend_reg[set_ad];
    dec = clr_en && pend_reg[clr_ad] && !(set_en && (set_ad == clr_ad));

    cnt_next = cnt_reg;
    if (inc && !dec)      cnt_next = cnt_reg + CNT_ONE;
    else if (dec && !inc) cnt_next = cnt_reg - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      pend_reg <= pend_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign pend = pend_reg;
  assign cnt  = cnt_reg;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read / one-write register file with an issue/writeback scoreboard.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   wr_en, wr_ad, wr_data    : write (writeback) port, clears pending
//   iss_en, iss_ad           : issue port, marks destination pending
//   addr_a/addr_b            : combinational read addresses
//   o_a/o_b                  : read data (optionally forwarded from wr_data)
//   busy_a/busy_b            : read register is pending
//   pend_cnt                 : registered count of pending registers
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1,
  localparam int AW = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_ad,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_ad,
  input  logic [AW-1:0]     addr_a,
  input  logic [AW-1:0]     addr_b,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic [AW:0]       pend_cnt
);

  logic [DATA_W-1:0] mem_reg [NREGS];
  logic [NREGS-1:0]  pend;
  logic              wr_live, iss_live;
  logic [AW-1:0]     rd_ad [2];

  // Effective strobes: reset masks everything, and a hardwired r0 swallows
  // writes and issues so they neither store, forward nor touch pend.
  assign wr_live  = wr_en  && !rst && !((ZERO_R0 != 0) && (wr_ad  == '0));
  assign iss_live = iss_en && !rst && !((ZERO_R0 != 0) && (iss_ad == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_reg[i] <= '0;
    end else if (wr_live) begin
      mem_reg[wr_ad] <= wr_data;
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .set_en (iss_live),
    .set_ad (iss_ad),
    .clr_en (wr_live),
    .clr_ad (wr_ad),
    .pend   (pend),
    .cnt    (pend_cnt)
  );

  assign rd_ad[0] = addr_a;
  assign rd_ad[1] = addr_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [DATA_W-1:0] data;
    logic              busy;

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (rst) begin
        // outputs held at zero during reset
      end else if ((ZERO_R0 != 0) && (rd_ad[gi] == '0)) begin
        // hardwired zero register
      end else if ((BYPASS != 0) && wr_live && (wr_ad == rd_ad[gi])) begin
        // Forwarded value is about to retire, so it is no longer pending.
        data = wr_data;
      end else begin
        data = mem_reg[rd_ad[gi]];
        busy = pend[rd_ad[gi]];
      end
    end
  end

  assign o_a    = g_rd[0].data;
  assign busy_a = g_rd[0].busy;
  assign o_b    = g_rd[1].data;
  assign busy_b = g_rd[1].busy;

endmodule
